muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide execution unit, parametrised in XLEN, attached beside the EX-stage ALU.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// The iterations work on operand magnitudes: shift-add for multiply, restoring for divide.
// The sign fix-up and result selection happen in FIN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start, busy=0
// S_RUN  | one multiply/divide iteration per cycle, XLEN cycles
// S_FIN  | sign fix-up, special-case override, result select
// S_DONE | done=1 for one cycle, busy=0, new start accepted
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            a_neg;
  logic            b_neg;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] opnd;
  // hi: running product high half / partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  logic            sgn_a;
  logic            sgn_b;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            in_div0;
  logic            in_ovf;

  // Operand decode for the cycle a start is accepted
  always_comb begin
    sgn_a    = (fun3 != 3'b011) && (fun3 != 3'b101) && (fun3 != 3'b111);
    sgn_b    = (fun3 == 3'b000) || (fun3 == 3'b001) ||
               (fun3 == 3'b100) || (fun3 == 3'b110);
    in_a_neg = sgn_a & a[XLEN-1];
    in_b_neg = sgn_b & b[XLEN-1];
    mag_a    = in_a_neg ? (~a + 1'b1) : a;
    mag_b    = in_b_neg ? (~b + 1'b1) : b;
    in_div0  = fun3[2] && (b == '0);
    in_ovf   = fun3[2] && !fun3[0] && (a == MIN_NEG) && (b == '1);
  end

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;

  // One iteration step; fun3[2] of the latched op selects divide
  always_comb begin
    addend    = lo[0] ? opnd : '0;
    mul_sum   = {1'b0, hi} + {1'b0, addend};
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    // Remainder stays below the divisor, so the low XLEN bits of the difference are exact
    div_sub   = div_shift[XLEN-1:0] - opnd;
    if (op[2]) begin
      hi_nxt = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_val;

  // Sign fix-up and result select; the special cases override the iterated values
  always_comb begin
    prod     = {hi, lo};
    prod_fix = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    if (div0) begin
      quot = '1;
      rem  = a_raw;
    end else if (ovf) begin
      quot = a_raw;
      rem  = '0;
    end else begin
      quot = (a_neg ^ b_neg) ? (~lo + 1'b1) : lo;
      rem  = a_neg ? (~hi + 1'b1) : hi;
    end
    case (op)
      3'b000:                 fin_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = quot;
      default:                fin_val = rem;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op    <= fun3;
            a_raw <= a;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            div0  <= in_div0;
            ovf   <= in_ovf;
            cnt   <= CW'(XLEN - 1);
            hi    <= '0;
            if (fun3[2]) begin
              lo   <= mag_a;
              opnd <= mag_b;
            end else begin
              lo   <= mag_b;
              opnd <= mag_a;
            end
            busy <= 1'b1;
            if (EARLY_OUT && (in_div0 || in_ovf)) state <= S_FIN;
            else                                  state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIN;
        end
        S_FIN: begin
          result <= fin_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32, EARLY_OUT=1).
// Expected results are queued when an op is issued and popped when done is seen.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      fun3 = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .fun3(fun3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] e;
    int              lat;
  } op_t;

  int              n_pass = 0;
  int              n_total = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0; returns in cycle 1
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y, input logic [XLEN-1:0] expv);
    fun3 = f; a = x; b = y; start = 1'b1;
    exp_q.push_back(expv);
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; reports the cycle it appeared in and busy cycles before it
  task automatic wait_done(output int cyc, output int busy_cnt, output logic got);
    cyc = 1; busy_cnt = 0; got = 1'b0;
    while (cyc < 200) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_latency();
    int cyc, bc; logic got; logic [XLEN-1:0] e;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    n_total++; if (busy !== 1'b1) $display("FAIL mul_busy_c1: got %b expected 1", busy); else n_pass++;
    wait_done(cyc, bc, got);
    e = exp_q.pop_front();
    n_total++; if (!got || result !== e) $display("FAIL mul_result: got %h (done=%b) expected %h", result, got, e); else n_pass++;
    last_res = e;
    n_total++; if (cyc != 34) $display("FAIL mul_done_cycle: got %0d expected 34", cyc); else n_pass++;
    n_total++; if (bc != 33) $display("FAIL mul_busy_cycles: got %0d expected 33", bc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mul_busy_in_done: got %b expected 0", busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL mul_done_width: got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_arith();
    op_t tbl[$];
    int cyc, bc; logic got; logic [XLEN-1:0] e;
    tbl.push_back('{3'b001, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 34});
    tbl.push_back('{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 34});
    tbl.push_back('{3'b011, 32'h80000000,  32'h80000000, 32'h40000000, 34});
    tbl.push_back('{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    tbl.push_back('{3'b010, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 34});
    tbl.push_back('{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    tbl.push_back('{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 34});
    tbl.push_back('{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34});
    tbl.push_back('{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34});
    tbl.push_back('{3'b101, 32'd100,       32'd7,        32'd14,       34});
    tbl.push_back('{3'b111, 32'd100,       32'd7,        32'd2,        34});
    tbl.push_back('{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    tbl.push_back('{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        34});
    tbl.push_back('{3'b101, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 34});
    tbl.push_back('{3'b101, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 34});
    tbl.push_back('{3'b111, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 34});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].e);
      wait_done(cyc, bc, got);
      e = exp_q.pop_front();
      n_total++; if (!got || result !== e) $display("FAIL arith_result[%0d] f=%b: got %h (done=%b) expected %h", i, tbl[i].f, result, got, e); else n_pass++;
      last_res = e;
      n_total++; if (cyc != tbl[i].lat) $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, cyc, tbl[i].lat); else n_pass++;
    end
  endtask

  task automatic test_special();
    op_t tbl[$];
    int cyc, bc; logic got; logic [XLEN-1:0] e;
    tbl.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2});
    tbl.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        2});
    tbl.push_back('{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 2});
    tbl.push_back('{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2});
    tbl.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    tbl.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].e);
      wait_done(cyc, bc, got);
      e = exp_q.pop_front();
      n_total++; if (!got || result !== e) $display("FAIL special_result[%0d] f=%b: got %h (done=%b) expected %h", i, tbl[i].f, result, got, e); else n_pass++;
      last_res = e;
      n_total++; if (cyc != tbl[i].lat) $display("FAIL special_latency[%0d]: got %0d expected %0d", i, cyc, tbl[i].lat); else n_pass++;
      n_total++; if (bc != 1) $display("FAIL special_busy_cycles[%0d]: got %0d expected 1", i, bc); else n_pass++;
    end
  endtask

  task automatic test_flush_reset();
    int cyc, bc, pulses; logic got; logic [XLEN-1:0] e;
    // Abort a MUL in cycle 10
    tick();
    fun3 = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL flush_done: got %b expected 0", done); else n_pass++;
    n_total++; if (result !== last_res) $display("FAIL flush_result_kept: got %h expected %h", result, last_res); else n_pass++;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    n_total++; if (pulses != 0) $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); else n_pass++;

    // Flush during DONE: done still visible, start ignored
    issue(3'b000, 32'd2, 32'd3, 32'd6);
    wait_done(cyc, bc, got);
    e = exp_q.pop_front();
    n_total++; if (!got || result !== e) $display("FAIL flushdone_result: got %h (done=%b) expected %h", result, got, e); else n_pass++;
    last_res = e;
    fun3 = 3'b101; a = 32'd8; b = 32'd1; start = 1'b1; flush = 1'b1;
    n_total++; if (done !== 1'b1) $display("FAIL flushdone_done_visible: got %b expected 1", done); else n_pass++;
    tick();
    start = 1'b0; flush = 1'b0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flushdone_start_ignored: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;

    // Start during DONE is accepted, then reset mid-RUN
    issue(3'b000, 32'd6, 32'd7, 32'd42);
    wait_done(cyc, bc, got);
    e = exp_q.pop_front();
    n_total++; if (!got || result !== e) $display("FAIL b2b_pre_result: got %h (done=%b) expected %h", result, got, e); else n_pass++;
    last_res = e;
    fun3 = 3'b101; a = 32'd9; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL done_start_accepted: got busy=%b expected 1", busy); else n_pass++;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0) $display("FAIL midrun_reset: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result); else n_pass++;
    tick();
    rst = 1'b0;
    last_res = '0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses, cyc, bc; int pc[$]; logic got; logic [XLEN-1:0] e;
    pulses = 0;
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd4);
    fun3 = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c == 1) begin
        fun3 = 3'b101; a = 32'd9; b = 32'd2;
      end
      if (done === 1'b1) begin
        pulses++;
        pc.push_back(c);
        e = exp_q.pop_front();
        n_total++; if (result !== e) $display("FAIL b2b_result[%0d]: got %h expected %h", pulses, result, e); else n_pass++;
        last_res = e;
      end
      tick();
    end
    start = 1'b0;
    n_total++; if (pulses != 2) $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); else n_pass++;
    n_total++; if (pc.size() < 1 || pc[0] != 34) $display("FAIL b2b_first_cycle: got %0d expected 34", (pc.size() > 0) ? pc[0] : -1); else n_pass++;
    n_total++; if (pc.size() < 2 || pc[1] != 68) $display("FAIL b2b_second_cycle: got %0d expected 68", (pc.size() > 1) ? pc[1] : -1); else n_pass++;
    // Start held through cycle 68 launched a third DIVU; drain it
    wait_done(cyc, bc, got);
    e = exp_q.pop_front();
    n_total++; if (!got || result !== e) $display("FAIL b2b_third_result: got %h (done=%b) expected %h", result, got, e); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_arith();
    test_special();
    test_flush_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
